// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants and helpers for the 4-digit seven-segment
// driver.
//   SEG_*      : active-low cathode patterns {g,f,e,d,c,b,a}
//   ANODE_OFF  : all digits disabled
//   ANODE_LAST : digit 3 enabled, the last digit of a scan frame
//   dsel_t / decode_anode : turn the scanner's one-hot anode into a digit index
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] ANODE_OFF  = 4'b1111;
  localparam logic [3:0] ANODE_LAST = 4'b0111;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } dsel_t;

  // Exactly one low bit is a valid digit; anything else (all high, several
  // low) is rejected so the board is driven dark rather than ghosting.
  function automatic dsel_t decode_anode(input logic [3:0] an);
    dsel_t s;
    s = '0;
    case (an)
      4'b1110: s = '{vld: 1'b1, idx: 2'd0};
      4'b1101: s = '{vld: 1'b1, idx: 2'd1};
      4'b1011: s = '{vld: 1'b1, idx: 2'd2};
      4'b0111: s = '{vld: 1'b1, idx: 2'd3};
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-low seven-segment decoder.
//   nib : 4-bit hex digit
//   seg : {g,f,e,d,c,b,a}, active-low
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_driver.sv
// seven_seg_driver: 4-digit multiplexed seven-segment output stage that follows
// the anode scanner. A loaded value is double-buffered and only swapped in at
// the frame boundary (anode == 0111), so a frame never mixes two values.
//   div_clock : scan clock (shared with the anode scanner)
//   reset     : synchronous, active-high
//   anode     : scanner anode, active-low one-hot, bit i = digit i
//   value     : 16-bit hex value, digit i = value[4i+3:4i]
//   dp_mask   : decimal-point enables, active-high, per digit
//   load      : strobe capturing value/dp_mask
//   blank_lz  : leading-zero blanking enable (live, not buffered)
//   anode_out : registered anode, active-low
//   cathode   : registered {g,f,e,d,c,b,a}, active-low
//   dp        : registered decimal point, active-low
//   pending   : a loaded value is waiting for the frame boundary
module seven_seg_driver
  import seven_seg_pkg::*;
(
  input  logic        div_clock,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  anode_out,
  output logic [6:0]  cathode,
  output logic        dp,
  output logic        pending
);

  logic [15:0] staged, shown;
  logic [3:0]  staged_dp, shown_dp;
  logic        pending_q;

  dsel_t       sel;
  logic [3:0]  nib;
  logic [6:0]  seg;
  logic [3:0]  lz;
  logic        blank;
  logic        boundary;

  assign sel      = decode_anode(anode);
  assign boundary = (anode == ANODE_LAST);
  assign nib      = shown[{sel.idx, 2'b00} +: 4];

  // lz[i]: nibble i and every higher nibble are zero. Digit 0 is always shown.
  assign lz[3] = (shown[15:12] == 4'h0);
  assign lz[2] = lz[3] && (shown[11:8] == 4'h0);
  assign lz[1] = lz[2] && (shown[7:4] == 4'h0);
  assign lz[0] = 1'b0;
  assign blank = blank_lz && lz[sel.idx];

  hex_to_seg u_dec (
    .nib (nib),
    .seg (seg)
  );

  always_ff @(posedge div_clock) begin
    if (reset) begin
      staged    <= '0;
      staged_dp <= '0;
      shown     <= '0;
      shown_dp  <= '0;
      pending_q <= 1'b0;
      anode_out <= ANODE_OFF;
      cathode   <= SEG_BLANK;
      dp        <= 1'b1;
    end else begin
      // Buffer swap. A load on the boundary goes straight to shown.
      if (boundary) begin
        if (load) begin
          shown    <= value;
          shown_dp <= dp_mask;
        end else if (pending_q) begin
          shown    <= staged;
          shown_dp <= staged_dp;
        end
        pending_q <= 1'b0;
      end else if (load) begin
        staged    <= value;
        staged_dp <= dp_mask;
        pending_q <= 1'b1;
      end

      // Outputs use the pre-swap shown, so the boundary edge still emits
      // digit 3 of the old frame.
      if (sel.vld) begin
        anode_out <= anode;
        cathode   <= blank ? SEG_BLANK : seg;
        dp        <= ~shown_dp[sel.idx];
      end else begin
        anode_out <= ANODE_OFF;
        cathode   <= SEG_BLANK;
        dp        <= 1'b1;
      end
    end
  end

  assign pending = pending_q;

endmodule

// File: tb/tb_seven_seg_driver.sv
// tb_seven_seg_driver: table-driven directed bench for seven_seg_driver plus
// hand-written reset sequences.
module tb_seven_seg_driver;

  logic        div_clock = 1'b0;
  logic        reset     = 1'b1;
  logic [3:0]  anode     = 4'b1111;
  logic [15:0] value     = '0;
  logic [3:0]  dp_mask   = '0;
  logic        load      = 1'b0;
  logic        blank_lz  = 1'b0;
  logic [3:0]  anode_out;
  logic [6:0]  cathode;
  logic        dp;
  logic        pending;

  int n_chk  = 0;
  int n_fail = 0;

  seven_seg_driver dut (
    .div_clock (div_clock),
    .reset     (reset),
    .anode     (anode),
    .value     (value),
    .dp_mask   (dp_mask),
    .load      (load),
    .blank_lz  (blank_lz),
    .anode_out (anode_out),
    .cathode   (cathode),
    .dp        (dp),
    .pending   (pending)
  );

  always #5 div_clock = ~div_clock;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000,
                         S8 = 7'b0000000, SA = 7'b0001000, SC = 7'b1000110,
                         SF = 7'b0001110, SX = 7'h7F;

  typedef struct {
    logic [3:0]  an;
    logic [15:0] val;
    logic [3:0]  dpm;
    logic        ld;
    logic        blz;
    logic [3:0]  e_an;
    logic [6:0]  e_cat;
    logic        e_dp;
    logic        e_pend;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] an, input logic [15:0] val,
                     input logic [3:0] dpm, input logic ld, input logic blz,
                     input logic [3:0] e_an, input logic [6:0] e_cat,
                     input logic e_dp, input logic e_pend);
    vec_t v;
    v.an = an; v.val = val; v.dpm = dpm; v.ld = ld; v.blz = blz;
    v.e_an = e_an; v.e_cat = e_cat; v.e_dp = e_dp; v.e_pend = e_pend;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge div_clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_an,
                            input logic [6:0] e_cat, input logic e_dp,
                            input logic e_pend);
    check({tag, ".anode_out"}, {12'h0, anode_out}, {12'h0, e_an});
    check({tag, ".cathode"},   {9'h0, cathode},    {9'h0, e_cat});
    check({tag, ".dp"},        {15'h0, dp},        {15'h0, e_dp});
    check({tag, ".pending"},   {15'h0, pending},   {15'h0, e_pend});
  endtask

  initial begin
    // an val dpm ld blz | e_an e_cat e_dp e_pend
    // reset exit: shown = 0
    add(4'b1110, 16'h0000, 4'h0, 0, 0, 4'b1110, S0, 1, 0);
    // full frame: load 12AF mid-frame
    add(4'b1101, 16'h12AF, 4'h0, 1, 0, 4'b1101, S0, 1, 1);
    add(4'b1011, 16'h0000, 4'h0, 0, 0, 4'b1011, S0, 1, 1);
    add(4'b0111, 16'h0000, 4'h0, 0, 0, 4'b0111, S0, 1, 0);
    add(4'b1110, 16'h0000, 4'h0, 0, 0, 4'b1110, SF, 1, 0);
    add(4'b1101, 16'h0000, 4'h0, 0, 0, 4'b1101, SA, 1, 0);
    add(4'b1011, 16'h0000, 4'h0, 0, 0, 4'b1011, S2, 1, 0);
    // boundary bypass of 1111
    add(4'b0111, 16'h1111, 4'h0, 1, 0, 4'b0111, S1, 1, 0);
    // tear-free: load 8888 mid-frame, rest of frame still 1s
    add(4'b1110, 16'h0000, 4'h0, 0, 0, 4'b1110, S1, 1, 0);
    add(4'b1101, 16'h8888, 4'h0, 1, 0, 4'b1101, S1, 1, 1);
    add(4'b1011, 16'h0000, 4'h0, 0, 0, 4'b1011, S1, 1, 1);
    add(4'b0111, 16'h0000, 4'h0, 0, 0, 4'b0111, S1, 1, 0);
    add(4'b1110, 16'h0000, 4'h0, 0, 0, 4'b1110, S8, 1, 0);
    add(4'b1101, 16'h0000, 4'h0, 0, 0, 4'b1101, S8, 1, 0);
    add(4'b1011, 16'h0000, 4'h0, 0, 0, 4'b1011, S8, 1, 0);
    // boundary bypass 00C5 with leading-zero blanking
    add(4'b0111, 16'h00C5, 4'h0, 1, 1, 4'b0111, S8, 1, 0);
    add(4'b1110, 16'h0000, 4'h0, 0, 1, 4'b1110, S5, 1, 0);
    add(4'b1101, 16'h0000, 4'h0, 0, 1, 4'b1101, SC, 1, 0);
    add(4'b1011, 16'h0000, 4'h0, 0, 1, 4'b1011, SX, 1, 0);
    // value 0, dp on digit 0: only digit 0 lit
    add(4'b0111, 16'h0000, 4'h1, 1, 1, 4'b0111, SX, 1, 0);
    add(4'b1110, 16'h0000, 4'h0, 0, 1, 4'b1110, S0, 0, 0);
    add(4'b1101, 16'h0000, 4'h0, 0, 1, 4'b1101, SX, 1, 0);
    add(4'b1011, 16'h0000, 4'h0, 0, 1, 4'b1011, SX, 1, 0);
    // value 0, dp on digit 2 (blanked digit keeps dp)
    add(4'b0111, 16'h0000, 4'h4, 1, 1, 4'b0111, SX, 1, 0);
    // invalid anodes
    add(4'b1100, 16'h0000, 4'h0, 0, 1, 4'b1111, SX, 1, 0);
    add(4'b1111, 16'h0000, 4'h0, 0, 1, 4'b1111, SX, 1, 0);
    add(4'b1110, 16'h0000, 4'h0, 0, 1, 4'b1110, S0, 1, 0);
    add(4'b1101, 16'h0000, 4'h0, 0, 1, 4'b1101, SX, 1, 0);
    add(4'b1011, 16'h0000, 4'h0, 0, 1, 4'b1011, SX, 0, 0);
    add(4'b0000, 16'h0000, 4'h0, 0, 1, 4'b1111, SX, 1, 0);
    // blanking off shows zeros; latest load wins
    add(4'b1110, 16'h1234, 4'h0, 1, 0, 4'b1110, S0, 1, 1);
    add(4'b1101, 16'h5678, 4'h0, 1, 0, 4'b1101, S0, 1, 1);
    add(4'b1011, 16'h0000, 4'h0, 0, 0, 4'b1011, S0, 0, 1);
    add(4'b0111, 16'h0000, 4'h0, 0, 0, 4'b0111, S0, 1, 0);
    add(4'b1110, 16'h0000, 4'h0, 0, 0, 4'b1110, S8, 1, 0);
    add(4'b1101, 16'h0000, 4'h0, 0, 0, 4'b1101, S7, 1, 0);
    add(4'b1011, 16'h0000, 4'h0, 0, 0, 4'b1011, S6, 1, 0);
    add(4'b0111, 16'h0000, 4'h0, 0, 0, 4'b0111, S5, 1, 0);

    // reset held two cycles
    reset = 1'b1;
    step();
    step();
    check_outs("reset", 4'b1111, SX, 1'b1, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      anode = vq[i].an; value = vq[i].val; dp_mask = vq[i].dpm;
      load = vq[i].ld; blank_lz = vq[i].blz;
      step();
      check_outs($sformatf("vec%0d", i), vq[i].e_an, vq[i].e_cat,
                 vq[i].e_dp, vq[i].e_pend);
    end
    load = 1'b0;

    // Reset mid-frame with a pending load: pending load is discarded and
    // reset wins over a coincident load.
    anode = 4'b1110; value = 16'hABCD; dp_mask = 4'hF; load = 1'b1;
    step();
    check_outs("pre_rst", 4'b1110, S8, 1'b1, 1'b1);
    anode = 4'b1101; value = 16'hEEEE; load = 1'b1; reset = 1'b1;
    step();
    check_outs("mid_rst", 4'b1111, SX, 1'b1, 1'b0);
    reset = 1'b0; load = 1'b0;
    anode = 4'b1011;
    step();
    check_outs("post_rst2", 4'b1011, S0, 1'b1, 1'b0);
    anode = 4'b0111;
    step();
    check_outs("post_rst3", 4'b0111, S0, 1'b1, 1'b0);
    anode = 4'b1110;
    step();
    check_outs("post_rst0", 4'b1110, S0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
